// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
// Holds the fetch PC, drives the instruction-memory address, and registers the fetched word for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        unused_target_bits;

    // Misaligned targets are silently forced to a word boundary; no trap is raised here.
    assign pc_plus4           = pc + 32'd4;
    assign target_aligned     = {redirect_target[31:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];
    assign imem_addr          = pc;

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // the pre-edge values of pc and imem_rdata, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= RESET_PC;
            if_id_pc_plus4 <= RESET_PC + 32'd4;
            if_id_valid    <= 1'b0;
        end else if (redirect) begin
            // Redirect beats stall: the wrong-path word in IF/ID is squashed to a bubble.
            pc             <= target_aligned;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] WRAP_RPC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        valid;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic [31:0] a_imem_addr, a_imem_rdata, a_pc, a_instr, a_ipc, a_ipc4;
    logic        a_valid;
    logic [31:0] b_imem_addr, b_imem_rdata, b_pc, b_instr, b_ipc, b_ipc4;
    logic        b_valid;

    int tests  = 0;
    int failed = 0;

    model_t m_a, m_b;
    bit     model_live = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign a_imem_rdata = word(a_imem_addr);
    assign b_imem_rdata = word(b_imem_addr);

    always #5 clk = ~clk;

    fetch_stage dut_a (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
        .pc(a_pc), .if_id_instr(a_instr), .if_id_pc(a_ipc),
        .if_id_pc_plus4(a_ipc4), .if_id_valid(a_valid)
    );

    fetch_stage #(.RESET_PC(WRAP_RPC)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .pc(b_pc), .if_id_instr(b_instr), .if_id_pc(b_ipc),
        .if_id_pc_plus4(b_ipc4), .if_id_valid(b_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what one clock edge does to the fetch state, from the stage's rules.
    function automatic model_t advance(input model_t m, input logic [31:0] reset_pc);
        model_t n = m;
        if (rst) begin
            n.pc = reset_pc; n.instr = NOP; n.ipc = reset_pc; n.ipc4 = reset_pc + 32'd4; n.valid = 1'b0;
        end else if (redirect) begin
            n.pc = redirect_target & ~32'h3; n.instr = NOP;
            n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.valid = 1'b0;
        end else if (!stall) begin
            n.instr = word(m.pc); n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.valid = 1'b1;
            n.pc = m.pc + 32'd4;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) model_live = 1'b1;
        m_a = advance(m_a, 32'h0);
        m_b = advance(m_b, WRAP_RPC);
    end

    // Compare both instances against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (model_live) begin
            check("a_pc", a_pc, m_a.pc);
            check("a_imem_addr", a_imem_addr, m_a.pc);
            check("a_instr", a_instr, m_a.instr);
            check("a_ipc", a_ipc, m_a.ipc);
            check("a_ipc4", a_ipc4, m_a.ipc4);
            check("a_valid", {31'b0, a_valid}, {31'b0, m_a.valid});
            check("b_pc", b_pc, m_b.pc);
            check("b_instr", b_instr, m_b.instr);
            check("b_ipc", b_ipc, m_b.ipc);
            check("b_ipc4", b_ipc4, m_b.ipc4);
            check("b_valid", {31'b0, b_valid}, {31'b0, m_b.valid});
        end
    end

    // Drive one cycle's inputs just after a falling edge, then wait for the next falling edge.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
        #1;
        rst = r; stall = s; redirect = rd; redirect_target = t;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0);
        check("lit_reset_pc", a_pc, 32'h0);
        check("lit_reset_instr", a_instr, NOP);
        check("lit_reset_valid", {31'b0, a_valid}, 32'h0);
        check("lit_reset_pc4", a_ipc4, 32'h4);

        // Free run from reset, plus wrap-around on the second instance.
        cyc(0, 0, 0, 0);
        check("lit_run1_pc", a_pc, 32'h4);
        check("lit_run1_instr", a_instr, 32'hA5A5_0000);
        check("lit_run1_valid", {31'b0, a_valid}, 32'h1);
        check("lit_wrap_pc", b_pc, 32'h0);
        check("lit_wrap_ipc", b_ipc, 32'hFFFF_FFFC);
        check("lit_wrap_ipc4", b_ipc4, 32'h0);
        repeat (3) cyc(0, 0, 0, 0);
        check("lit_run4_pc", a_pc, 32'h10);
        check("lit_run4_ipc", a_ipc, 32'hC);
        check("lit_run4_instr", a_instr, 32'hA5A5_000C);

        // Two stall cycles freeze everything, then resume.
        repeat (2) cyc(0, 1, 0, 0);
        check("lit_stall_pc", a_pc, 32'h10);
        check("lit_stall_ipc", a_ipc, 32'hC);
        check("lit_stall_instr", a_instr, 32'hA5A5_000C);
        cyc(0, 0, 0, 0);
        check("lit_resume_pc", a_pc, 32'h14);
        check("lit_resume_ipc", a_ipc, 32'h10);

        // Redirect, then first instruction from the target.
        cyc(0, 0, 1, 32'h100);
        check("lit_redir_pc", a_pc, 32'h100);
        check("lit_redir_instr", a_instr, NOP);
        check("lit_redir_valid", {31'b0, a_valid}, 32'h0);
        cyc(0, 0, 0, 0);
        check("lit_tgt_ipc", a_ipc, 32'h100);
        check("lit_tgt_valid", {31'b0, a_valid}, 32'h1);

        // Redirect with stall, misaligned target, back-to-back redirects.
        cyc(0, 1, 1, 32'h40);
        check("lit_stallredir_pc", a_pc, 32'h40);
        check("lit_stallredir_instr", a_instr, NOP);
        cyc(0, 0, 1, 32'h203);
        check("lit_align_pc", a_pc, 32'h200);
        cyc(0, 0, 1, 32'h404);
        check("lit_b2b_pc", a_pc, 32'h404);
        check("lit_b2b_valid", {31'b0, a_valid}, 32'h0);

        // Redirect on the first cycle after reset.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h500);
        check("lit_rstredir_pc", a_pc, 32'h500);
        check("lit_rstredir_valid", {31'b0, a_valid}, 32'h0);
        cyc(0, 0, 0, 0);
        check("lit_rstredir_ipc", a_ipc, 32'h500);

        // Reset during a stall.
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("lit_rststall_pc", a_pc, 32'h0);
        check("lit_rststall_instr", a_instr, NOP);
        check("lit_rststall_valid", {31'b0, a_valid}, 32'h0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
